// File: rtl/elevator_scheduler.sv
// elevator_scheduler
// Four-stop car scheduler (floors 0..3). Latches calls, picks the next stop
// with a collective SCAN policy, times travel and door dwell on the tick
// timebase and publishes floor/status as registered outputs.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE 00 | stationary, door closed; decides next action every clk
//   MOVE 01 | travelling toward a pending call, travel timer running
//   DOOR 10 | door open at current floor, dwell timer running
//   --  11  | unused encoding, recovers to IDLE
module elevator_scheduler #(
   parameter int TRAVEL_TICKS = 4,
   parameter int DOOR_TICKS   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] call_req,
   output logic [3:0] call_pending,
   output logic [1:0] floor,
   output logic [1:0] state,
   output logic       moving,
   output logic       dir_up,
   output logic       door_open,
   output logic       arrive
);

   localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
   localparam int CW        = $clog2(MAX_TICKS + 1);

   localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_TICKS);
   localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_TICKS);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MOVE = 2'b01,
      ST_DOOR = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t        st_q;
   logic [CW-1:0] travel_cnt;
   logic [CW-1:0] door_cnt;

   logic [3:0] pend_set;
   logic [1:0] nxt_floor;
   logic       here;
   logic       above;
   logic       below;
   logic       nxt_hit;
   logic       nxt_beyond;
   logic       travel_tc;
   logic       door_tc;

   // Floors strictly above f.
   function automatic logic [3:0] gt_mask(input logic [1:0] f);
      logic [3:0] m;
      case (f)
         2'd0:    m = 4'b1110;
         2'd1:    m = 4'b1100;
         2'd2:    m = 4'b1000;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Floors strictly below f.
   function automatic logic [3:0] lt_mask(input logic [1:0] f);
      logic [3:0] m;
      case (f)
         2'd0:    m = 4'b0000;
         2'd1:    m = 4'b0001;
         2'd2:    m = 4'b0011;
         default: m = 4'b0111;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] f);
      return 4'b0001 << f;
   endfunction

   assign state = st_q;

   // Request summaries and next-floor lookahead used by the sequencer.
   always_comb begin
      pend_set   = call_pending | call_req;
      here       = call_pending[floor];
      above      = |(call_pending & gt_mask(floor));
      below      = |(call_pending & lt_mask(floor));
      nxt_floor  = dir_up ? (floor + 2'd1) : (floor - 2'd1);
      // The arrival decision sees calls raised on the arrival edge itself.
      nxt_hit    = pend_set[nxt_floor];
      nxt_beyond = dir_up ? |(pend_set & gt_mask(nxt_floor))
                          : |(pend_set & lt_mask(nxt_floor));
      // Terminal count at 1; a stray 0 is also treated as terminal.
      travel_tc  = (travel_cnt <= CNT_ONE);
      door_tc    = (door_cnt <= CNT_ONE);
   end

   // Sequencer: call latch, state, timers and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q         <= ST_IDLE;
         floor        <= 2'd0;
         dir_up       <= 1'b1;
         call_pending <= 4'b0000;
         moving       <= 1'b0;
         door_open    <= 1'b0;
         arrive       <= 1'b0;
         travel_cnt   <= '0;
         door_cnt     <= '0;
      end else begin
         call_pending <= pend_set;
         arrive       <= 1'b0;
         case (st_q)
            ST_IDLE: begin
               if (here) begin
                  st_q         <= ST_DOOR;
                  door_open    <= 1'b1;
                  moving       <= 1'b0;
                  door_cnt     <= DOOR_LOAD;
                  call_pending <= pend_set & ~onehot(floor);
               end else if (above && (dir_up || !below)) begin
                  st_q       <= ST_MOVE;
                  dir_up     <= 1'b1;
                  moving     <= 1'b1;
                  travel_cnt <= TRAVEL_LOAD;
               end else if (below) begin
                  st_q       <= ST_MOVE;
                  dir_up     <= 1'b0;
                  moving     <= 1'b1;
                  travel_cnt <= TRAVEL_LOAD;
               end
            end
            ST_MOVE: begin
               if (tick) begin
                  if (travel_tc) begin
                     floor  <= nxt_floor;
                     arrive <= 1'b1;
                     if (nxt_hit) begin
                        st_q         <= ST_DOOR;
                        moving       <= 1'b0;
                        door_open    <= 1'b1;
                        door_cnt     <= DOOR_LOAD;
                        call_pending <= pend_set & ~onehot(nxt_floor);
                     end else if (nxt_beyond) begin
                        travel_cnt <= TRAVEL_LOAD;
                     end else begin
                        st_q   <= ST_IDLE;
                        moving <= 1'b0;
                     end
                  end else begin
                     travel_cnt <= travel_cnt - CNT_ONE;
                  end
               end
            end
            ST_DOOR: begin
               // A press at the open floor keeps the door open rather than queueing.
               if (call_req[floor]) begin
                  door_cnt     <= DOOR_LOAD;
                  call_pending <= pend_set & ~onehot(floor);
               end else if (tick) begin
                  if (door_tc) begin
                     st_q      <= ST_IDLE;
                     door_open <= 1'b0;
                  end else begin
                     door_cnt <= door_cnt - CNT_ONE;
                  end
               end
            end
            default: begin
               st_q      <= ST_IDLE;
               moving    <= 1'b0;
               door_open <= 1'b0;
            end
         endcase
      end
   end

endmodule
